// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_IDX  = 9;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Synchronises the raw RX pin and exposes the 3-sample majority and falling-edge of the
// synchronised line.
module uart_bit_sampler
  import uart_pkg::*;
(
  input  logic clk_48,
  input  logic reset,
  input  logic serial,
  output logic rx_s,
  output logic majority,
  output logic fall_edge
);

  logic       sync_q;
  logic [1:0] hist;

  // Everything resets to the idle (high) line level so no false edge appears after reset.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      hist   <= 2'b11;
    end else begin
      sync_q <= serial;
      rx_s   <= sync_q;
      hist   <= {hist[0], rx_s};
    end
  end

  assign majority  = majority3({hist, rx_s});
  assign fall_edge = hist[0] & ~rx_s;

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 oversampling UART receiver with majority-voted mid-bit sampling and a one-deep
// valid/ready holding register.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DIVISOR   = 16,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk_48,
  input  logic                 reset,
  input  logic                 serial,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int PHASE_W = $clog2(DIVISOR);
  localparam logic [PHASE_W-1:0] MID_PHASE  = PHASE_W'(DIVISOR / 2);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DIVISOR - 1);

  rx_state_t            state;
  logic [PHASE_W-1:0]   phase;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  logic rx_s;
  logic majority;
  logic fall_edge;
  logic at_mid;
  logic at_last;
  logic deliver;

  uart_bit_sampler u_sampler (
    .clk_48    (clk_48),
    .reset     (reset),
    .serial    (serial),
    .rx_s      (rx_s),
    .majority  (majority),
    .fall_edge (fall_edge)
  );

  // The edge cycle itself is phase 0 of the start bit while the register only reads 0 one
  // cycle later, so the third mid-bit sample lands when the register holds MID.
  // NOTE: every signal written here gets a value first, so no latch is inferred.
  always_comb begin
    at_mid  = (phase == MID_PHASE);
    at_last = (phase == LAST_PHASE);
    deliver = (state == STOP) && at_mid && majority;
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_edge) begin
            phase   <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          phase <= phase + 1'b1;
          if (at_mid && majority) begin
            state <= IDLE;
          end else if (at_last) begin
            phase   <= '0;
            bit_idx <= 4'd1;
            state   <= DATA;
          end
        end
        DATA: begin
          phase <= phase + 1'b1;
          if (at_mid) begin
            shift_reg <= {majority, shift_reg[DATA_BITS-1:1]};
          end
          if (at_last) begin
            phase   <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'(DATA_BITS)) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          phase <= phase + 1'b1;
          if (at_mid) begin
            if (majority) begin
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completed byte is only lost when the consumer is not draining the current one.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (data_valid && !data_ready) begin
          overrun <= 1'b1;
        end else begin
          data       <= shift_reg;
          data_valid <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
